// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU operation sequencer.
package alu_seq_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, RESP} alu_seq_state_t;

   localparam int ALU_SEL_W    = 3;
   localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to an external combinational ALU, waits a fixed
// settle time, captures the result and returns it over a valid/ready channel.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [WIDTH-1:0]     cmd_a,
   input  logic [WIDTH-1:0]     cmd_b,
   input  logic [ALU_SEL_W-1:0] cmd_sel,
   input  logic                 cmd_chain,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [ALU_SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_carry,
   input  logic                 alu_zero,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH-1:0]     rsp_result,
   output logic                 rsp_carry,
   output logic                 rsp_zero,
   output logic                 busy,
   output logic [CNT_W-1:0]     op_count
);

   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE);

   alu_seq_state_t          state_q, state_d;
   logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]        alu_a_q, alu_a_d;
   logic [WIDTH-1:0]        alu_b_q, alu_b_d;
   logic [ALU_SEL_W-1:0]    alu_sel_q, alu_sel_d;
   logic [WIDTH-1:0]        rsp_result_q, rsp_result_d;
   logic                    rsp_carry_q, rsp_carry_d;
   logic                    rsp_zero_q, rsp_zero_d;
   logic [WIDTH-1:0]        last_result_q, last_result_d;
   logic [CNT_W-1:0]        op_count_q, op_count_d;
   logic                    accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= alu_seq_pkg::IDLE;
         cnt_q         <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_sel_q     <= '0;
         rsp_result_q  <= '0;
         rsp_carry_q   <= 1'b0;
         rsp_zero_q    <= 1'b0;
         last_result_q <= '0;
         op_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_sel_q     <= alu_sel_d;
         rsp_result_q  <= rsp_result_d;
         rsp_carry_q   <= rsp_carry_d;
         rsp_zero_q    <= rsp_zero_d;
         last_result_q <= last_result_d;
         op_count_q    <= op_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_sel_d     = alu_sel_q;
      rsp_result_d  = rsp_result_q;
      rsp_carry_d   = rsp_carry_q;
      rsp_zero_d    = rsp_zero_q;
      last_result_d = last_result_q;
      op_count_d    = op_count_q;
      cmd_ready     = 1'b0;
      accept        = 1'b0;

      unique case (state_q)
         alu_seq_pkg::IDLE: begin
            cmd_ready = 1'b1;
            accept    = cmd_valid;
         end
         alu_seq_pkg::SETTLE: begin
            cnt_d = cnt_q - SETTLE_CNT_W'(1);
            if (cnt_q == SETTLE_CNT_W'(1)) begin
               rsp_result_d  = alu_result;
               rsp_carry_d   = alu_carry;
               rsp_zero_d    = alu_zero;
               last_result_d = alu_result;
               state_d       = alu_seq_pkg::RESP;
            end
         end
         alu_seq_pkg::RESP: begin
            // A new command can only ride on the response handshake.
            cmd_ready = rsp_ready;
            if (rsp_ready) begin
               op_count_d = op_count_q + CNT_W'(1);
               state_d    = alu_seq_pkg::IDLE;
               accept     = cmd_valid;
            end
         end
         default: state_d = alu_seq_pkg::IDLE;
      endcase

      // last_result_q already holds this op's capture when accepting from RESP.
      if (accept) begin
         alu_a_d   = cmd_chain ? last_result_q : cmd_a;
         alu_b_d   = cmd_b;
         alu_sel_d = cmd_sel;
         cnt_d     = SETTLE_LOAD;
         state_d   = alu_seq_pkg::SETTLE;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign rsp_valid  = (state_q == alu_seq_pkg::RESP);
   assign rsp_result = rsp_result_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_zero   = rsp_zero_q;
   assign busy       = (state_q != alu_seq_pkg::IDLE);
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with SETTLE=1, one with
// SETTLE=3 and a narrow counter, each driving an adder model as the ALU.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // SETTLE=1 instance
   logic       c1_valid, c1_ready, c1_chain, r1_ready, r1_valid;
   logic       r1_carry, r1_zero, busy1, a1_carry, a1_zero;
   logic [7:0] c1_a, c1_b, a1_a, a1_b, a1_result, r1_result;
   logic [2:0] c1_sel, a1_sel;
   logic [15:0] cnt1;

   // SETTLE=3 instance
   logic       c3_valid, c3_ready, c3_chain, r3_ready, r3_valid;
   logic       r3_carry, r3_zero, busy3, a3_carry, a3_zero;
   logic [7:0] c3_a, c3_b, a3_a, a3_b, a3_result, r3_result;
   logic [2:0] c3_sel, a3_sel;
   logic [1:0] cnt3;

   assign {a1_carry, a1_result} = {1'b0, a1_a} + {1'b0, a1_b};
   assign a1_zero = (a1_result == 8'd0);
   assign {a3_carry, a3_result} = {1'b0, a3_a} + {1'b0, a3_b};
   assign a3_zero = (a3_result == 8'd0);

   alu_op_sequencer #(.WIDTH(8), .SETTLE(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst),
      .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_a(c1_a), .cmd_b(c1_b),
      .cmd_sel(c1_sel), .cmd_chain(c1_chain),
      .alu_a(a1_a), .alu_b(a1_b), .alu_sel(a1_sel),
      .alu_result(a1_result), .alu_carry(a1_carry), .alu_zero(a1_zero),
      .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_result(r1_result),
      .rsp_carry(r1_carry), .rsp_zero(r1_zero), .busy(busy1), .op_count(cnt1)
   );

   alu_op_sequencer #(.WIDTH(8), .SETTLE(3), .CNT_W(2)) u_dut3 (
      .clk(clk), .rst(rst),
      .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_a(c3_a), .cmd_b(c3_b),
      .cmd_sel(c3_sel), .cmd_chain(c3_chain),
      .alu_a(a3_a), .alu_b(a3_b), .alu_sel(a3_sel),
      .alu_result(a3_result), .alu_carry(a3_carry), .alu_zero(a3_zero),
      .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_result(r3_result),
      .rsp_carry(r3_carry), .rsp_zero(r3_zero), .busy(busy3), .op_count(cnt3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      c1_valid = 0; c1_a = 0; c1_b = 0; c1_sel = 0; c1_chain = 0; r1_ready = 0;
      c3_valid = 0; c3_a = 0; c3_b = 0; c3_sel = 0; c3_chain = 0; r3_ready = 0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_cmd_ready", c1_ready, 1);
      chk("rst_rsp_valid", r1_valid, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_op_count", cnt1, 0);
      chk("rst_alu_a", a1_a, 0);
      chk("rst_rsp_result", r1_result, 0);
      rst = 1'b0;
      tick;

      // 10 + 3, SETTLE=1
      c1_valid = 1; c1_a = 8'd10; c1_b = 8'd3; c1_sel = 3'd2; r1_ready = 1;
      tick;
      c1_valid = 0;
      chk("t1_busy", busy1, 1);
      chk("t1_rsp_valid_early", r1_valid, 0);
      chk("t1_alu_a", a1_a, 8'd10);
      chk("t1_alu_sel", a1_sel, 3'd2);
      chk("t1_cmd_ready_settle", c1_ready, 0);
      tick;
      chk("t1_rsp_valid", r1_valid, 1);
      chk("t1_result", r1_result, 8'd13);
      chk("t1_carry", r1_carry, 0);
      chk("t1_zero", r1_zero, 0);
      tick;
      chk("t1_op_count", cnt1, 1);
      chk("t1_back_idle", r1_valid, 0);

      // FF + 01 wraps to zero with carry
      c1_valid = 1; c1_a = 8'hFF; c1_b = 8'h01;
      tick;
      c1_valid = 0;
      tick;
      chk("t2_result", r1_result, 8'h00);
      chk("t2_carry", r1_carry, 1);
      chk("t2_zero", r1_zero, 1);
      tick;
      chk("t2_op_count", cnt1, 2);

      // Chain accepted on the response handshake
      c1_valid = 1; c1_a = 8'd10; c1_b = 8'd3;
      tick;
      c1_valid = 0;
      tick;
      chk("t3_first_result", r1_result, 8'd13);
      c1_valid = 1; c1_chain = 1; c1_a = 8'hAA; c1_b = 8'd5;
      #1;
      chk("t3_cmd_ready_resp", c1_ready, 1);
      tick;
      c1_valid = 0; c1_chain = 0;
      chk("t3_chain_alu_a", a1_a, 8'd13);
      chk("t3_chain_alu_b", a1_b, 8'd5);
      chk("t3_op_count", cnt1, 3);
      chk("t3_in_settle", r1_valid, 0);
      tick;
      chk("t3_chain_result", r1_result, 8'd18);
      tick;
      chk("t3_op_count2", cnt1, 4);

      // Back-pressure for 5 cycles
      r1_ready = 0;
      c1_valid = 1; c1_a = 8'd7; c1_b = 8'd9;
      tick;
      c1_valid = 0;
      tick;
      for (int i = 0; i < 5; i++) begin
         c1_valid = 1; c1_a = 8'd1; c1_b = 8'd1;
         #1;
         chk("t4_hold_result", r1_result, 8'd16);
         chk("t4_hold_valid", r1_valid, 1);
         chk("t4_hold_count", cnt1, 4);
         chk("t4_cmd_ready", c1_ready, 0);
         tick;
      end
      c1_valid = 0; r1_ready = 1;
      tick;
      chk("t4_release_count", cnt1, 5);
      chk("t4_release_valid", r1_valid, 0);
      tick;
      chk("t4_single_incr", cnt1, 5);

      // SETTLE=3: operands held 3 cycles, commands in SETTLE ignored
      r3_ready = 0;
      c3_valid = 1; c3_a = 8'd20; c3_b = 8'd22;
      tick;
      c3_a = 8'd99; c3_b = 8'd1;
      for (int i = 0; i < 3; i++) begin
         chk("t5_alu_a_stable", a3_a, 8'd20);
         chk("t5_alu_b_stable", a3_b, 8'd22);
         chk("t5_no_rsp", r3_valid, 0);
         chk("t5_cmd_ready", c3_ready, 0);
         tick;
      end
      chk("t5_rsp_valid", r3_valid, 1);
      chk("t5_result", r3_result, 8'd42);
      chk("t5_cmd_ready_resp_low", c3_ready, 0);
      r3_ready = 1;
      #1;
      chk("t5_cmd_ready_resp_high", c3_ready, 1);
      tick;
      c3_valid = 0;
      chk("t5_held_cmd_alu_a", a3_a, 8'd99);
      chk("t5_op_count", cnt3, 1);

      // Asynchronous reset in the middle of SETTLE
      #2 rst = 1'b1;
      #1;
      chk("t6_busy", busy3, 0);
      chk("t6_rsp_valid", r3_valid, 0);
      chk("t6_alu_a", a3_a, 0);
      chk("t6_alu_b", a3_b, 0);
      chk("t6_op_count", cnt3, 0);
      chk("t6_cmd_ready", c3_ready, 1);
      chk("t6_dut1_count", cnt1, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t6_no_rsp", r3_valid, 0);
         tick;
      end
      c3_valid = 1; c3_chain = 1; c3_a = 8'd50; c3_b = 8'd4;
      tick;
      c3_valid = 0; c3_chain = 0;
      chk("t6_chain_after_rst", a3_a, 0);
      repeat (3) tick;
      chk("t6_rsp_valid_after", r3_valid, 1);
      chk("t6_result_after", r3_result, 8'd4);
      tick;
      chk("t6_count_after", cnt3, 1);

      // Narrow counter wraps 3 -> 0
      for (int i = 1; i <= 3; i++) begin
         c3_valid = 1; c3_a = 8'(i); c3_b = 8'(i);
         tick;
         c3_valid = 0;
         repeat (3) tick;
         chk("t7_result", r3_result, 32'(2 * i));
         tick;
      end
      chk("t7_count_wrap", cnt3, 0);
      chk("t7_idle", busy3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential initiator that issues operations to the team's combinational ALU and returns the results. It accepts one command at a time over a valid/ready handshake and drives the ALU operand and select lines from registers. After a fixed settle time it captures Result/CarryOut/Zero and presents them on a valid/ready response channel. It sits between a controller or stimulus source and an `ALU #(.WIDTH)` instance, and supports chaining the previous result into operand A.

## Interface
- `WIDTH`, 8: operand/result width; must match the attached ALU.
- `SETTLE`, 1: cycles operands are held on the ALU before capture; legal range 1..15.
- `CNT_W`, 16: width of the completed-operation counter.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer accepts the command this cycle.
- `cmd_a`, `cmd_b`  in  WIDTH: operands.
- `cmd_sel`  in  3: ALU select; passed through opaque.
- `cmd_chain`  in  1: use the last captured result as A; `cmd_a` is ignored.
- `alu_a`, `alu_b`  out  WIDTH: to ALU `A`, `B`.
- `alu_sel`  out  3: to ALU `ALU_Sel`.
- `alu_result`  in  WIDTH: from ALU `Result`.
- `alu_carry`, `alu_zero`  in  1: from ALU `CarryOut`, `Zero`.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer takes the response.
- `rsp_result`  out  WIDTH: captured result.
- `rsp_carry`, `rsp_zero`  out  1: captured flags.
- `busy`  out  1: state is not IDLE.
- `op_count`  out  CNT_W: number of completed responses.

## Operation
- FSM has three states: IDLE, SETTLE, RESP.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`, register `alu_a` as `cmd_chain ? last_result : cmd_a`, and register `alu_b`/`alu_sel` from the command.
  - Load the settle counter with `SETTLE`, then go to SETTLE.
- SETTLE
  - Decrement the counter each cycle.
  - On the edge where the counter equals 1, capture `alu_result`/`alu_carry`/`alu_zero` into the `rsp_*` registers and into `last_result`, then go to RESP.
- RESP
  - `rsp_valid`=1.
  - On `rsp_ready`, increment `op_count`.
  - If `cmd_valid` is also high, accept the new command in that same cycle (`cmd_ready` = `rsp_ready` in RESP) and go to SETTLE; otherwise go to IDLE.
- Chaining always uses the most recently captured result. This includes back-to-back acceptance in RESP, because capture precedes that handshake.
- Chain before any capture since reset uses `last_result`=0.
- `alu_*` hold their last driven values in IDLE and RESP; they do not return to zero.
- `rsp_*` hold stable while `rsp_valid && !rsp_ready`.
- `op_count` wraps from 2^CNT_W−1 to 0.
- Commands presented in SETTLE are not accepted; `cmd_ready`=0.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `rsp_valid`=0, `busy`=0; `alu_a`/`alu_b`/`alu_sel`, `rsp_*`, `last_result` and `op_count` all 0.
- Latency: command accepted at edge N → `rsp_valid` high after edge N+SETTLE.
- Throughput: with `rsp_ready` tied high, one op per SETTLE+1 cycles.
- `alu_*` change only on the acceptance edge, so the ALU sees stable inputs for exactly SETTLE cycles before capture.
- Reset mid-operation forces all outputs to reset values immediately (asynchronous). The in-flight command is dropped and does not count.
- `cmd_ready` depends combinationally on `rsp_ready` in RESP only. No other combinational input-to-output paths.

## Structure
- Package `alu_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, SETTLE, RESP} alu_seq_state_t`
  - `localparam ALU_SEL_W = 3`
  - `localparam SETTLE_CNT_W = 4`
- Single module, no sub-modules; the ALU is instantiated beside it by the integrator.
- Bench instantiates `alu_op_sequencer` with a combinational responder model:
  - `{carry, result} = A + B`
  - `zero = (result == 0)`
  - `sel` ignored

## Test plan
- Reset, then a=10, b=3, chain=0, SETTLE=1, rsp_ready=1 → `rsp_valid` one cycle after accept; `rsp_result`=13, carry=0, zero=0; `op_count`=1.
- a=8'hFF, b=8'h01 → `rsp_result`=0, carry=1, zero=1.
- Chain: a=10, b=3, then chain=1, b=5 presented during RESP with `rsp_ready`=1 → second accepted in the handshake cycle; `alu_a`=13, result=18.
- `rsp_ready` held low 5 cycles → `rsp_*` stable, `cmd_ready`=0, `op_count` unchanged; release → single increment.
- SETTLE=3 → `alu_*` stable 3 cycles and capture on the 3rd edge; `cmd_valid` during SETTLE is ignored until RESP/IDLE.
- Assert `rst` mid-SETTLE → outputs return to reset values immediately, no response emitted, `op_count`=0; next command completes normally.
